// File: rtl/mm_combiner_fifo.sv
// mm_combiner_fifo
//   Register-mapped N-channel FIFO combiner. The host pushes words into
//   NUM_CH input FIFOs through the write port. A rate-limited engine pops
//   one word from every channel and pushes one combined word (OR/AND/XOR/ADD)
//   into an output FIFO, which the host drains through the read port.
//
// Ports
//   CLK            clock, all logic on posedge
//   RST            synchronous active-high reset
//   write_address  write target (0..NUM_CH-1 CHk, 8 CTRL, 9 INTERVAL, 10 CLR, 13 ERR clear)
//   write_data     write payload
//   write_en       write strobe, accepted only when write_rdy
//   write_rdy      write can be accepted this cycle
//   read_address   read target (0..NUM_CH-1 CHk peek, 8 CTRL, 9 INTERVAL, 11 STATUS, 12 OUT pop, 13 ERR)
//   read_en        read strobe, pops OUT only when read_rdy
//   read_data      combinational read data
//   read_rdy       read target valid this cycle
//
// Configuration
//   MM_COMBINER_ERR_CNT_EN : when defined, address 13 is a saturating counter
//   of dropped writes/reads; otherwise it reads 0 and writes are ignored.

module mm_combiner_fifo #(
  parameter int NUM_CH = 2,
  parameter int W      = 8,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [W-1:0]      write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read_en,
  output logic [W-1:0]      read_data,
  output logic              read_rdy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT      = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_INTERVAL = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ADDR_CLR      = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] ADDR_OUT      = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] ADDR_ERR      = ADDR_W'(13);

  logic [2:0]        ctrl;
  logic [W-1:0]      interval;
  logic [W-1:0]      gap_cnt;
  logic [NUM_CH-1:0] wr_sel, rd_sel, ch_full, ch_empty;
  logic [W-1:0]      ch_head [NUM_CH];
  logic              clr_wr, fire, all_ne, any_full;
  logic              out_full, out_empty, out_pop;
  logic [W-1:0]      out_head, combined, err_val;

  // CLR wins over everything else happening in the same cycle
  assign clr_wr    = write_en && (write_address == ADDR_CLR);
  assign all_ne    = ~|ch_empty;
  assign any_full  = |ch_full;
  assign fire      = ctrl[2] && all_ne && !out_full && (gap_cnt >= interval) && !clr_wr;
  // only channel addresses can back-pressure a write
  assign write_rdy = ~|(wr_sel & ch_full);
  assign out_pop   = read_en && (read_address == ADDR_OUT) && !out_empty;

  // Input FIFOs: push from host, pop on fire; a push to a full channel is
  // rejected from pre-edge occupancy even if a fire frees a slot this cycle.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;

    assign wr_sel[k]   = (write_address == ADDR_W'(k));
    assign rd_sel[k]   = (read_address == ADDR_W'(k));
    assign push        = write_en && wr_sel[k] && !ch_full[k];
    assign ch_full[k]  = (cnt == FULL_CNT);
    assign ch_empty[k] = (cnt == '0);
    assign ch_head[k]  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= write_data;
    end

    always_ff @(posedge CLK) begin
      if (RST || clr_wr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !fire)      cnt <= cnt + CNT_W'(1);
        else if (fire && !push) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Output FIFO: push on fire, pop on host read of OUT
  logic [W-1:0]     out_mem [DEPTH];
  logic [PTR_W-1:0] out_wr_ptr, out_rd_ptr;
  logic [CNT_W-1:0] out_cnt;

  assign out_full  = (out_cnt == FULL_CNT);
  assign out_empty = (out_cnt == '0);
  assign out_head  = out_mem[out_rd_ptr];

  always_ff @(posedge CLK) begin
    if (fire) out_mem[out_wr_ptr] <= combined;
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_wr) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (fire)    out_wr_ptr <= out_wr_ptr + PTR_W'(1);
      if (out_pop) out_rd_ptr <= out_rd_ptr + PTR_W'(1);
      if (fire && !out_pop)      out_cnt <= out_cnt + CNT_W'(1);
      else if (out_pop && !fire) out_cnt <= out_cnt - CNT_W'(1);
    end
  end

  // Fold all channel heads with the selected operator; ADD drops the carry
  always_comb begin
    combined = ch_head[0];
    for (int k = 1; k < NUM_CH; k++) begin
      case (ctrl[1:0])
        2'd0:    combined = combined | ch_head[k];
        2'd1:    combined = combined & ch_head[k];
        2'd2:    combined = combined ^ ch_head[k];
        default: combined = combined + ch_head[k];
      endcase
    end
  end

  // Control registers and the inter-fire gap counter (saturating)
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl     <= 3'b100;
      interval <= '0;
      gap_cnt  <= '0;
    end else begin
      if (write_en && (write_address == ADDR_CTRL))     ctrl     <= write_data[2:0];
      if (write_en && (write_address == ADDR_INTERVAL)) interval <= write_data;
      if (fire || clr_wr)        gap_cnt <= '0;
      else if (gap_cnt != '1)    gap_cnt <= gap_cnt + W'(1);
    end
  end

`ifdef MM_COMBINER_ERR_CNT_EN
  // Counts cycles with a dropped write or read; a clear write takes priority
  logic [W-1:0] err_cnt;
  logic         dropped;

  assign dropped = (write_en && !write_rdy) || (read_en && !read_rdy);

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (write_en && (write_address == ADDR_ERR)) begin
      err_cnt <= '0;
    end else if (dropped && (err_cnt != '1)) begin
      err_cnt <= err_cnt + W'(1);
    end
  end

  assign err_val = err_cnt;
`else
  assign err_val = '0;
`endif

  // Read mux; FIFO addresses return 0 whenever they have nothing to offer
  always_comb begin
    read_data = '0;
    read_rdy  = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_sel[k]) begin
        read_rdy  = !ch_empty[k];
        read_data = ch_empty[k] ? '0 : ch_head[k];
      end
    end
    case (read_address)
      ADDR_CTRL:     read_data = {{(W-3){1'b0}}, ctrl};
      ADDR_INTERVAL: read_data = interval;
      ADDR_STATUS:   read_data = {{(W-4){1'b0}}, any_full, all_ne, out_full, !out_empty};
      ADDR_OUT: begin
        read_rdy  = !out_empty;
        read_data = out_empty ? '0 : out_head;
      end
      ADDR_ERR:      read_data = err_val;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mm_combiner_fifo.sv
// tb_mm_combiner_fifo
//   Directed bench for mm_combiner_fifo (NUM_CH=2, W=8, DEPTH=2, ADDR_W=4).
//   Expected combined words are queued when the channel words are pushed and
//   popped when the DUT presents them at OUT.

module tb_mm_combiner_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] write_address, read_address;
  logic [7:0] write_data, read_data;
  logic       write_en, write_rdy, read_en, read_rdy;

  int         checks = 0;
  int         passed = 0;
  int         failed = 0;
  logic [7:0] expq [$];
  logic [1:0] curMode;
  logic [7:0] errExp;
  int         t1, t2;

  always #5 CLK = ~CLK;

  mm_combiner_fifo #(
    .NUM_CH(2),
    .W(8),
    .DEPTH(2),
    .ADDR_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .write_address(write_address),
    .write_data(write_data),
    .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address),
    .read_en(read_en),
    .read_data(read_data),
    .read_rdy(read_rdy)
  );

  // Reference combine of two channel heads
  function automatic logic [7:0] combineModel(input logic [1:0] mode, input logic [7:0] a,
                                              input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (mode)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return sum[7:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One host write, held for a single clock edge
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    write_address = addr;
    write_data    = data;
    write_en      = 1'b1;
    tick();
    write_en      = 1'b0;
  endtask

  task automatic pushPair(input logic [7:0] a, input logic [7:0] b);
    applyStimulus(4'd0, a);
    applyStimulus(4'd1, b);
    expq.push_back(combineModel(curMode, a, b));
  endtask

  task automatic checkRead(input string tag, input logic [3:0] addr, input logic [7:0] expData,
                           input logic expRdy);
    read_address = addr;
    #1;
    checkOutput({tag, "_data"}, {24'd0, read_data}, {24'd0, expData});
    checkOutput({tag, "_rdy"}, {31'd0, read_rdy}, {31'd0, expRdy});
  endtask

  task automatic waitOut(input string tag, input int maxCycles);
    int n;
    read_address = 4'd12;
    #1;
    n = 0;
    while (!read_rdy && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rdy"}, {31'd0, read_rdy}, 32'd1);
  endtask

  task automatic popOut(input string tag);
    logic [7:0] exp;
    waitOut(tag, 20);
    exp = (expq.size() > 0) ? expq.pop_front() : 8'h00;
    checkOutput(tag, {24'd0, read_data}, {24'd0, exp});
    read_en = read_rdy;
    tick();
    read_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef MM_COMBINER_ERR_CNT_EN
    errExp = 8'd1;
`else
    errExp = 8'd0;
`endif
    RST           = 1'b1;
    write_address = 4'd15;
    write_data    = 8'h00;
    write_en      = 1'b0;
    read_address  = 4'd15;
    read_en       = 1'b0;
    curMode       = 2'd0;
    repeat (2) tick();
    RST = 1'b0;

    // Reset state
    checkRead("rst_ch0", 4'd0, 8'h00, 1'b0);
    write_address = 4'd0;
    #1;
    checkOutput("rst_wrdy0", {31'd0, write_rdy}, 32'd1);
    checkRead("rst_out", 4'd12, 8'h00, 1'b0);
    checkRead("rst_ctrl", 4'd8, 8'h04, 1'b1);
    tick();
    checkRead("rst_interval", 4'd9, 8'h00, 1'b1);
    checkRead("rst_status", 4'd11, 8'h00, 1'b1);
    checkRead("rst_unmapped", 4'd15, 8'h00, 1'b1);
    checkRead("rst_err", 4'd13, 8'h00, 1'b1);
    tick();

    // Test 1: OR, latency of push + fire
    $display("[TB] test 1: OR and latency");
    applyStimulus(4'd0, 8'h0F);
    checkRead("t1_peek0", 4'd0, 8'h0F, 1'b1);
    applyStimulus(4'd1, 8'hF0);
    expq.push_back(combineModel(curMode, 8'h0F, 8'hF0));
    checkRead("t1_status_pre", 4'd11, 8'h04, 1'b1);
    tick();
    checkRead("t1_status_post", 4'd11, 8'h01, 1'b1);
    popOut("t1_out");
    checkRead("t1_out_empty", 4'd12, 8'h00, 1'b0);

    // Test 2: other modes, and a disabled engine holding data back
    $display("[TB] test 2: modes");
    applyStimulus(4'd8, 8'h05);
    curMode = 2'd1;
    checkRead("t2_ctrl", 4'd8, 8'h05, 1'b1);
    pushPair(8'h3C, 8'h0F);
    popOut("t2_and");
    applyStimulus(4'd8, 8'h07);
    curMode = 2'd3;
    pushPair(8'hFF, 8'h02);
    popOut("t2_add");
    pushPair(8'hFF, 8'h01);
    popOut("t2_add_wrap");
    applyStimulus(4'd8, 8'h06);
    curMode = 2'd2;
    pushPair(8'hAA, 8'hFF);
    popOut("t2_xor");
    applyStimulus(4'd8, 8'h03);
    curMode = 2'd3;
    pushPair(8'h10, 8'h20);
    repeat (4) tick();
    checkRead("t2_disabled", 4'd11, 8'h04, 1'b1);
    applyStimulus(4'd8, 8'h07);
    popOut("t2_reenable");

    // Test 3: INTERVAL spacing between fires
    $display("[TB] test 3: interval");
    applyStimulus(4'd8, 8'h00);
    curMode = 2'd0;
    applyStimulus(4'd9, 8'd50);
    pushPair(8'h11, 8'h22);
    pushPair(8'h44, 8'h88);
    repeat (60) tick();
    checkRead("t3_filled", 4'd11, 8'h0C, 1'b1);
    applyStimulus(4'd8, 8'h04);
    read_address = 4'd11;
    #1;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 150; c++) begin
      if (t1 < 0 && read_data[0]) t1 = c;
      if (t2 < 0 && read_data[1]) t2 = c;
      tick();
    end
    checkOutput("t3_first_fire", t1, 32'd1);
    checkOutput("t3_spacing_ok", {31'd0, (t2 >= 0) && (t2 - t1 >= 50) && (t2 - t1 <= 52)}, 32'd1);
    checkRead("t3_status", 4'd11, 8'h03, 1'b1);
    popOut("t3_out0");
    popOut("t3_out1");
    applyStimulus(4'd9, 8'd0);

    // Test 4: full channel back-pressure and dropped push
    $display("[TB] test 4: back-pressure");
    applyStimulus(4'd0, 8'hA1);
    applyStimulus(4'd0, 8'hA2);
    write_address = 4'd0;
    #1;
    checkOutput("t4_wrdy_full", {31'd0, write_rdy}, 32'd0);
    write_address = 4'd8;
    #1;
    checkOutput("t4_wrdy_other", {31'd0, write_rdy}, 32'd1);
    applyStimulus(4'd0, 8'hA3);
    checkRead("t4_peek0", 4'd0, 8'hA1, 1'b1);
    checkRead("t4_status", 4'd11, 8'h08, 1'b1);
    checkRead("t4_err", 4'd13, errExp, 1'b1);
    applyStimulus(4'd13, 8'h00);
    checkRead("t4_err_clr", 4'd13, 8'h00, 1'b1);
    applyStimulus(4'd1, 8'h01);
    expq.push_back(combineModel(curMode, 8'hA1, 8'h01));
    applyStimulus(4'd1, 8'h02);
    expq.push_back(combineModel(curMode, 8'hA2, 8'h02));
    repeat (3) tick();
    checkRead("t4_out_full", 4'd11, 8'h03, 1'b1);

    // Test 5: OUT full stalls the engine; order kept across wrap
    $display("[TB] test 5: OUT full stall");
    applyStimulus(4'd0, 8'h10);
    applyStimulus(4'd0, 8'h20);
    applyStimulus(4'd1, 8'h01);
    applyStimulus(4'd1, 8'h02);
    expq.push_back(combineModel(curMode, 8'h10, 8'h01));
    expq.push_back(combineModel(curMode, 8'h20, 8'h02));
    repeat (3) tick();
    checkRead("t5_stalled", 4'd11, 8'h0F, 1'b1);
    popOut("t5_out0");
    checkRead("t5_after_pop", 4'd11, 8'h0D, 1'b1);
    tick();
    checkRead("t5_after_fire", 4'd11, 8'h07, 1'b1);
    popOut("t5_out1");
    popOut("t5_out2");
    popOut("t5_out3");
    checkRead("t5_drained", 4'd11, 8'h00, 1'b1);

    // Test 6: CLR beats a ready fire; then reset mid-stream
    $display("[TB] test 6: CLR and reset");
    applyStimulus(4'd9, 8'd3);
    applyStimulus(4'd0, 8'h55);
    applyStimulus(4'd1, 8'h66);
    applyStimulus(4'd10, 8'h00);
    checkRead("t6_status", 4'd11, 8'h00, 1'b1);
    checkRead("t6_ch0", 4'd0, 8'h00, 1'b0);
    checkRead("t6_out", 4'd12, 8'h00, 1'b0);
    repeat (3) tick();
    checkRead("t6_status_later", 4'd11, 8'h00, 1'b1);
    checkRead("t6_ctrl_kept", 4'd8, 8'h04, 1'b1);
    checkRead("t6_interval_kept", 4'd9, 8'd3, 1'b1);

    applyStimulus(4'd8, 8'h06);
    applyStimulus(4'd9, 8'd7);
    applyStimulus(4'd0, 8'h12);
    applyStimulus(4'd1, 8'h34);
    applyStimulus(4'd0, 8'h56);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkRead("t6_rst_ctrl", 4'd8, 8'h04, 1'b1);
    checkRead("t6_rst_interval", 4'd9, 8'h00, 1'b1);
    checkRead("t6_rst_status", 4'd11, 8'h00, 1'b1);
    checkRead("t6_rst_ch0", 4'd0, 8'h00, 1'b0);
    tick();
    checkRead("t6_rst_out", 4'd12, 8'h00, 1'b0);
    curMode = 2'd0;
    pushPair(8'h0F, 8'hF0);
    popOut("t6_post_rst");
    checkOutput("sb_drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
